// File: rtl/game_sequencer_if.sv
// -----------------------------------------------------------------------------
// game_sequencer_if
// Bundles the player/playfield status inputs and the sequencer control/status
// outputs of the snake game sequencer.
//   master : the surrounding game logic (drives go/overlap/wall_hit/self_hit,
//            observes the sequencer outputs)
//   slave  : the game_sequencer itself
// Signals:
//   go          player begin/restart request (level)
//   overlap     snake head is on the food
//   wall_hit    snake head left the playfield
//   self_hit    snake head hit its own body
//   food_start  hold/initialise the food block
//   food_update one-cycle request to relocate the food
//   move_en     one-cycle snake step strobe
//   grow        one-cycle snake extend strobe
//   score       foods eaten this game
//   state       current sequencer state encoding
//   game_over   high while the game is over
//   win         high while over after reaching the maximum score
// -----------------------------------------------------------------------------
interface game_sequencer_if;
    logic       go;
    logic       overlap;
    logic       wall_hit;
    logic       self_hit;
    logic       food_start;
    logic       food_update;
    logic       move_en;
    logic       grow;
    logic [7:0] score;
    logic [2:0] state;
    logic       game_over;
    logic       win;

    modport master (
        output go, overlap, wall_hit, self_hit,
        input  food_start, food_update, move_en, grow, score, state, game_over, win
    );

    modport slave (
        input  go, overlap, wall_hit, self_hit,
        output food_start, food_update, move_en, grow, score, state, game_over, win
    );
endinterface

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Top-level control FSM for a snake game: waits for the player, initialises a
// round, paces snake movement with a tick divider, handles eating/food
// relocation and ends the game on collision or on reaching MAX_SCORE.
// Ports:
//   clk    system clock, rising edge
//   start  synchronous active-high reset
//   bus    game_sequencer_if.slave (status inputs, control/status outputs)
// Parameters:
//   TICK_DIV   clk cycles per snake step (2..65535)
//   MAX_SCORE  score that ends the game as a win
// Every output comes straight from a register; the registers are loaded from
// the next-state decode so each output matches the state it is shown with.
// -----------------------------------------------------------------------------
module game_sequencer #(
    parameter int TICK_DIV  = 4,
    parameter int MAX_SCORE = 99
) (
    input  logic             clk,
    input  logic             start,
    game_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_EAT   = 3'd3,
        ST_RELOC = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [7:0]  SCORE_MAX = 8'(MAX_SCORE);
    // The wait counter is 0 in the first RELOC cycle; a re-pulse decided at
    // count 14 becomes visible in the 16th RELOC cycle, i.e. 16 cycles after
    // the previous food_update. The 4-bit wrap restarts the wait by itself.
    localparam logic [3:0]  WAIT_LAST = 4'd14;

    state_t      r_state;
    logic [15:0] r_tick;
    logic [3:0]  r_wait;
    logic [7:0]  r_score;
    logic        r_win;
    logic        r_game_over;
    logic        r_food_start;
    logic        r_food_update;
    logic        r_move_en;
    logic        r_grow;

    state_t      w_next_state;
    logic        w_collide;
    logic        w_tick_wrap;

    assign w_collide   = bus.wall_hit | bus.self_hit;
    assign w_tick_wrap = (r_tick == TICK_LAST);

    // Next-state decode; collisions outrank food in PLAY and RELOC.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.go) begin
                    w_next_state = ST_INIT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_INIT: begin
                w_next_state = ST_PLAY;
            end
            ST_PLAY: begin
                if (w_collide) begin
                    w_next_state = ST_OVER;
                end else if (bus.overlap) begin
                    w_next_state = ST_EAT;
                end else begin
                    w_next_state = ST_PLAY;
                end
            end
            ST_EAT: begin
                // score was already incremented on entry to EAT
                if (r_score >= SCORE_MAX) begin
                    w_next_state = ST_OVER;
                end else begin
                    w_next_state = ST_RELOC;
                end
            end
            ST_RELOC: begin
                if (w_collide) begin
                    w_next_state = ST_OVER;
                end else if (!bus.overlap) begin
                    w_next_state = ST_PLAY;
                end else begin
                    w_next_state = ST_RELOC;
                end
            end
            ST_OVER: begin
                if (bus.go) begin
                    w_next_state = ST_INIT;
                end else begin
                    w_next_state = ST_OVER;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; start overrides everything.
    always_ff @(posedge clk) begin
        if (start) begin
            r_state       <= ST_IDLE;
            r_tick        <= 16'd0;
            r_wait        <= 4'd0;
            r_score       <= 8'd0;
            r_win         <= 1'b0;
            r_game_over   <= 1'b0;
            r_food_start  <= 1'b1;
            r_food_update <= 1'b0;
            r_move_en     <= 1'b0;
            r_grow        <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // tick divider only runs while playing; frozen elsewhere
            if (w_next_state == ST_INIT) begin
                r_tick <= 16'd0;
            end else if (r_state == ST_PLAY) begin
                r_tick <= w_tick_wrap ? 16'd0 : (r_tick + 16'd1);
            end else begin
                r_tick <= r_tick;
            end

            // every RELOC cycle after the first is an overlap cycle, so the
            // wait counter just counts RELOC cycles
            if (r_state == ST_RELOC) begin
                r_wait <= r_wait + 4'd1;
            end else begin
                r_wait <= 4'd0;
            end

            if (w_next_state == ST_INIT) begin
                r_score <= 8'd0;
            end else if ((w_next_state == ST_EAT) && (r_score < SCORE_MAX)) begin
                r_score <= r_score + 8'd1;
            end else begin
                r_score <= r_score;
            end

            if (w_next_state == ST_INIT) begin
                r_win <= 1'b0;
            end else if ((r_state == ST_EAT) && (w_next_state == ST_OVER)) begin
                r_win <= 1'b1;
            end else begin
                r_win <= r_win;
            end

            r_game_over   <= (w_next_state == ST_OVER);
            r_food_start  <= (w_next_state == ST_IDLE) || (w_next_state == ST_INIT);
            r_grow        <= (w_next_state == ST_EAT);
            r_food_update <= (w_next_state == ST_EAT) ||
                             ((r_state == ST_RELOC) && (w_next_state == ST_RELOC) &&
                              (r_wait == WAIT_LAST));
            // a wrap on a cycle that leaves PLAY produces no step
            r_move_en     <= (r_state == ST_PLAY) && (w_next_state == ST_PLAY) && w_tick_wrap;
        end
    end

    assign bus.state       = r_state;
    assign bus.score       = r_score;
    assign bus.win         = r_win;
    assign bus.game_over   = r_game_over;
    assign bus.food_start  = r_food_start;
    assign bus.food_update = r_food_update;
    assign bus.move_en     = r_move_en;
    assign bus.grow        = r_grow;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
// Directed scoreboard bench for game_sequencer (TICK_DIV=4, MAX_SCORE=3).
// The stimulus process drives one input vector per cycle on the falling edge
// and queues the hand-computed output vector expected after the next rising
// edge; the monitor pops and compares shortly after each rising edge.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

    // input vector bits: {start, go, overlap, wall_hit, self_hit}
    localparam logic [4:0] I_NONE = 5'b00000;
    localparam logic [4:0] I_RST  = 5'b10000;
    localparam logic [4:0] I_GO   = 5'b01000;
    localparam logic [4:0] I_OVL  = 5'b00100;
    localparam logic [4:0] I_WALL = 5'b00010;
    localparam logic [4:0] I_SELF = 5'b00001;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_EAT   = 3'd3;
    localparam logic [2:0] S_RELOC = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    // flag bits: {food_start, food_update, move_en, grow, game_over, win}
    localparam logic [5:0] F_NO = 6'b000000;
    localparam logic [5:0] F_FS = 6'b100000;
    localparam logic [5:0] F_FU = 6'b010000;
    localparam logic [5:0] F_ME = 6'b001000;
    localparam logic [5:0] F_GR = 6'b000100;
    localparam logic [5:0] F_GO = 6'b000010;
    localparam logic [5:0] F_WN = 6'b000001;

    typedef struct {
        int          idx;
        logic [16:0] exp;
    } exp_t;

    logic clk;
    logic start;
    int   n_cmp;
    int   n_bad;
    int   step_no;
    exp_t q[$];

    game_sequencer_if bus_if ();

    game_sequencer #(
        .TICK_DIV  (4),
        .MAX_SCORE (3)
    ) dut (
        .clk   (clk),
        .start (start),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic [4:0] in_v, input logic [2:0] st,
                        input logic [7:0] sc, input logic [5:0] fl);
        exp_t e;
        @(negedge clk);
        start           = in_v[4];
        bus_if.go       = in_v[3];
        bus_if.overlap  = in_v[2];
        bus_if.wall_hit = in_v[1];
        bus_if.self_hit = in_v[0];
        step_no         = step_no + 1;
        e.idx           = step_no;
        e.exp           = {st, sc, fl};
        q.push_back(e);
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation.
    always @(posedge clk) begin
        exp_t        e;
        logic [16:0] act;
        #1;
        if (q.size() != 0) begin
            e   = q.pop_front();
            act = {bus_if.state, bus_if.score, bus_if.food_start, bus_if.food_update,
                   bus_if.move_en, bus_if.grow, bus_if.game_over, bus_if.win};
            n_cmp = n_cmp + 1;
            if (act !== e.exp) begin
                n_bad = n_bad + 1;
                $display("FAIL step%0d: got state=%0d score=%0d flags(fs,fu,me,gr,go,wn)=%b, expected state=%0d score=%0d flags=%b",
                         e.idx, act[16:14], act[13:6], act[5:0],
                         e.exp[16:14], e.exp[13:6], e.exp[5:0]);
            end
        end
    end

    initial begin
        n_cmp           = 0;
        n_bad           = 0;
        step_no         = 0;
        start           = 1'b1;
        bus_if.go       = 1'b0;
        bus_if.overlap  = 1'b0;
        bus_if.wall_hit = 1'b0;
        bus_if.self_hit = 1'b0;

        // reset for two cycles, then first cycle evaluated as IDLE
        step(I_RST,  S_IDLE, 8'd0, F_FS);
        step(I_RST,  S_IDLE, 8'd0, F_FS);
        step(I_NONE, S_IDLE, 8'd0, F_FS);
        step(I_GO,   S_INIT, 8'd0, F_FS);
        step(I_NONE, S_PLAY, 8'd0, F_NO);
        // move_en every 4th cycle, first 4 cycles after entering PLAY; go ignored
        step(I_GO,   S_PLAY, 8'd0, F_NO);
        step(I_NONE, S_PLAY, 8'd0, F_NO);
        step(I_NONE, S_PLAY, 8'd0, F_NO);
        step(I_NONE, S_PLAY, 8'd0, F_ME);
        step(I_NONE, S_PLAY, 8'd0, F_NO);
        step(I_NONE, S_PLAY, 8'd0, F_NO);
        step(I_NONE, S_PLAY, 8'd0, F_NO);
        step(I_NONE, S_PLAY, 8'd0, F_ME);

        // overlap for 3 cycles: EAT, RELOC, back to PLAY with tick frozen in RELOC
        step(I_OVL,         S_EAT,   8'd1, F_FU | F_GR);
        step(I_OVL,         S_RELOC, 8'd1, F_NO);
        step(I_OVL | I_GO,  S_RELOC, 8'd1, F_NO);
        step(I_NONE,        S_PLAY,  8'd1, F_NO);
        step(I_NONE,        S_PLAY,  8'd1, F_NO);
        step(I_NONE,        S_PLAY,  8'd1, F_NO);
        step(I_NONE,        S_PLAY,  8'd1, F_ME);

        // overlap held through RELOC: re-pulse in the 16th RELOC cycle only
        step(I_OVL, S_EAT, 8'd2, F_FU | F_GR);
        for (int i = 1; i <= 20; i++) begin
            step(I_OVL, S_RELOC, 8'd2, (i == 16) ? F_FU : F_NO);
        end
        step(I_NONE, S_PLAY, 8'd2, F_NO);
        step(I_NONE, S_PLAY, 8'd2, F_NO);
        step(I_NONE, S_PLAY, 8'd2, F_NO);
        step(I_NONE, S_PLAY, 8'd2, F_ME);

        // collision together with overlap: OVER, no grow, score unchanged
        step(I_WALL | I_OVL, S_OVER, 8'd2, F_GO);
        step(I_NONE,         S_OVER, 8'd2, F_GO);
        step(I_GO,           S_INIT, 8'd0, F_FS);
        step(I_NONE,         S_PLAY, 8'd0, F_NO);

        // start asserted mid-RELOC with score 2
        step(I_OVL,         S_EAT,   8'd1, F_FU | F_GR);
        step(I_NONE,        S_RELOC, 8'd1, F_NO);
        step(I_NONE,        S_PLAY,  8'd1, F_NO);
        step(I_OVL,         S_EAT,   8'd2, F_FU | F_GR);
        step(I_OVL,         S_RELOC, 8'd2, F_NO);
        step(I_RST | I_OVL, S_IDLE,  8'd0, F_FS);
        step(I_OVL,         S_IDLE,  8'd0, F_FS);

        // three eats reach MAX_SCORE=3 -> OVER with win, then restart clears it
        step(I_GO,   S_INIT,  8'd0, F_FS);
        step(I_NONE, S_PLAY,  8'd0, F_NO);
        step(I_OVL,  S_EAT,   8'd1, F_FU | F_GR);
        step(I_NONE, S_RELOC, 8'd1, F_NO);
        step(I_NONE, S_PLAY,  8'd1, F_NO);
        step(I_OVL,  S_EAT,   8'd2, F_FU | F_GR);
        step(I_NONE, S_RELOC, 8'd2, F_NO);
        step(I_NONE, S_PLAY,  8'd2, F_NO);
        step(I_OVL,  S_EAT,   8'd3, F_FU | F_GR);
        step(I_NONE, S_OVER,  8'd3, F_GO | F_WN);
        step(I_NONE, S_OVER,  8'd3, F_GO | F_WN);
        step(I_GO,   S_INIT,  8'd0, F_FS);
        step(I_NONE, S_PLAY,  8'd0, F_NO);

        // wall hit in RELOC, self hit in PLAY
        step(I_OVL,          S_EAT,   8'd1, F_FU | F_GR);
        step(I_OVL,          S_RELOC, 8'd1, F_NO);
        step(I_WALL | I_OVL, S_OVER,  8'd1, F_GO);
        step(I_GO,           S_INIT,  8'd0, F_FS);
        step(I_NONE,         S_PLAY,  8'd0, F_NO);
        step(I_SELF,         S_OVER,  8'd0, F_GO);
        step(I_NONE,         S_OVER,  8'd0, F_GO);

        // bounded drain of the scoreboard
        repeat (4) @(posedge clk);
        #2;
        n_cmp = n_cmp + 1;
        if (q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001: Parameter TICK_DIV, default 4: clk cycles per snake move step; legal range 2..65535.
REQ-002: Parameter MAX_SCORE, default 99: score value that ends the game as a win.
REQ-003: clk  input  1  single system clock; all logic on the rising edge.
REQ-004: start  input  1  reset, synchronous, active-high; one clock, reset is synchronous and active-high.
REQ-005: go  input  1  player begin/restart request, level-sampled each clk.
REQ-006: overlap  input  1  snake head overlaps food, from the food block.
REQ-007: wall_hit  input  1  snake head outside the playfield.
REQ-008: self_hit  input  1  snake head overlaps its own body.
REQ-009: food_start  output  1  hold/initialise the food block; connects to the food block's start.
REQ-010: food_update  output  1  one-cycle pulse that tells the food block to relocate.
REQ-011: move_en  output  1  one-cycle pulse that advances the snake one step.
REQ-012: grow  output  1  one-cycle pulse that extends the snake by one segment.
REQ-013: score  output  8  foods eaten in the current game, binary.
REQ-014: state  output  3  current FSM state encoding (IDLE=0, INIT=1, PLAY=2, EAT=3, RELOC=4, OVER=5).
REQ-015: game_over  output  1  high while in OVER.
REQ-016: win  output  1  high while in OVER if the game ended at MAX_SCORE.

Function
REQ-017: All outputs SHALL be registered; no input-to-output combinational path.
REQ-018: IDLE: food_start=1; score and win hold. go=1 -> INIT.
REQ-019: INIT: lasts exactly one cycle. food_start=1, score<=0, win<=0, tick counter<=0. Then -> PLAY.
REQ-020: PLAY: food_start=0. The tick counter increments each cycle and wraps from TICK_DIV-1 to 0. move_en pulses for 1 cycle on the cycle the counter wraps.
REQ-021: PLAY priority, evaluated each cycle: (wall_hit|self_hit) -> OVER; else overlap -> EAT; else stay.
REQ-022: A collision and overlap in the same cycle SHALL go to OVER, with no grow or score change.
REQ-023: EAT: lasts exactly one cycle. grow=1, food_update=1, score<=score+1. If score+1==MAX_SCORE -> OVER with win<=1; else -> RELOC.
REQ-024: RELOC: no move_en, and the tick counter is frozen. overlap==0 -> PLAY. If overlap stays high for 16 consecutive cycles, food_update re-pulses once and the 16-cycle wait restarts.
REQ-025: wall_hit or self_hit in RELOC -> OVER (same priority as PLAY).
REQ-026: OVER: game_over=1. move_en, grow and food_update stay 0. score holds. go=1 -> INIT.
REQ-027: go SHALL be ignored in PLAY, EAT and RELOC.
REQ-028: score SHALL never exceed MAX_SCORE and SHALL never wrap.
REQ-029: move_en, grow and food_update SHALL each be high for at most one cycle per triggering event.

Reset
REQ-030: start=1 on a clk edge SHALL force state=IDLE, score=0, win=0, game_over=0, tick counter=0, move_en=grow=food_update=0, food_start=1, from any state including mid-EAT/RELOC.
REQ-031: start SHALL take priority over every other input in the same cycle.
REQ-032: The first cycle after start deasserts SHALL be evaluated as IDLE.

Verification
REQ-033: start 2 cycles, go=1 for 1 cycle -> INIT for 1 cycle, then PLAY; move_en pulses every 4th cycle (TICK_DIV=4), first pulse 4 cycles after entering PLAY.
REQ-034: In PLAY, assert overlap for 3 cycles -> EAT for 1 cycle (grow=food_update=1, score 0->1), RELOC until overlap falls, then PLAY; no move_en during RELOC.
REQ-035: In PLAY, assert wall_hit and overlap together -> OVER next cycle, score unchanged, grow=0, game_over=1, win=0.
REQ-036: MAX_SCORE=3; three eat events -> third EAT goes to OVER with score=3, win=1; go=1 -> INIT, score=0, win=0.
REQ-037: In RELOC, hold overlap high for 20 cycles -> a second food_update pulse on the 16th cycle; then drop overlap -> PLAY.
REQ-038: Assert start mid-RELOC with score=2 -> next cycle state=IDLE, score=0, food_start=1, all pulse outputs 0.
